clock_set_ctrl: RTL and testbench

- Time-set controller for the real-time clock datapath (time base → seconds/minutes/hours counters → BCD → SSD).
- Two user buttons (MODE, INC) drive it.
- It pauses counting, walks the user through editing hours, minutes and seconds, and issues a single synchronous load of the edited time into the counters.
- It also drives per-field blink masks for the display stage and aborts an idle edit on timeout.

---
 rtl/clock_set_ctrl_pkg.sv | 38 +++
 rtl/clock_set_ctrl_if.sv | 29 ++
 rtl/clock_set_ctrl_btn_sync_edge.sv | 26 ++
 rtl/clock_set_ctrl.sv | 160 ++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and constants for the RTC time-set controller.
package clock_set_ctrl_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam int HOURS_MAX_DFLT     = 23;
    localparam int MIN_SEC_MAX_DFLT   = 59;
    localparam int HOLD_TICKS_DFLT    = 2;
    localparam int TIMEOUT_TICKS_DFLT = 30;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_H,
        ST_SET_M,
        ST_SET_S,
        ST_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        FIELD_NONE    = 2'd0,
        FIELD_HOURS   = 2'd1,
        FIELD_MINUTES = 2'd2,
        FIELD_SECONDS = 2'd3
    } field_t;

    // Blank mask {hours, minutes, seconds} with only the edited pair blinking.
    function automatic logic [2:0] field_mask(field_t f, logic phase);
        case (f)
            FIELD_HOURS:   return {phase, 2'b00};
            FIELD_MINUTES: return {1'b0, phase, 1'b0};
            FIELD_SECONDS: return {2'b00, phase};
            default:       return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button/counter/display signal bundle between the set controller and its neighbours.
interface clock_set_ctrl_if;
    import clock_set_ctrl_pkg::*;

    logic              tick;
    logic              btn_mode;
    logic              btn_inc;
    logic [SEC_W-1:0]  q_seconds;
    logic [MIN_W-1:0]  q_minutes;
    logic [HOUR_W-1:0] q_hours;
    logic              run_en;
    logic              load;
    logic [SEC_W-1:0]  load_seconds;
    logic [MIN_W-1:0]  load_minutes;
    logic [HOUR_W-1:0] load_hours;
    logic [1:0]        edit_field;
    logic [2:0]        blank_mask;

    modport slave (
        input  tick, btn_mode, btn_inc, q_seconds, q_minutes, q_hours,
        output run_en, load, load_seconds, load_minutes, load_hours, edit_field, blank_mask
    );

    modport master (
        output tick, btn_mode, btn_inc, q_seconds, q_minutes, q_hours,
        input  run_en, load, load_seconds, load_minutes, load_hours, edit_field, blank_mask
    );

endinterface

// File: rtl/clock_set_ctrl_btn_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge pulse for one raw button.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pulse
);

    // [0],[1] synchronizer, [2] delayed copy for edge detect
    logic [2:0] sync_pipe;

    assign level = sync_pipe[1];

    // Shift the raw level through the synchronizer and register the edge pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_pipe <= '0;
            pulse     <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[1:0], raw};
            pulse     <= sync_pipe[1] & ~sync_pipe[2];
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: pauses counters, edits h/m/s, loads edited time once.
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int HOURS_MAX     = HOURS_MAX_DFLT,
    parameter int MIN_SEC_MAX   = MIN_SEC_MAX_DFLT,
    parameter int HOLD_TICKS    = HOLD_TICKS_DFLT,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DFLT
) (
    input logic              clk,
    input logic              reset,
    clock_set_ctrl_if.slave  bus
);

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_TICKS);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_TICKS - 1);
    localparam logic [HOUR_W-1:0] H_MAX     = HOUR_W'(HOURS_MAX);
    localparam logic [MIN_W-1:0]  M_MAX     = MIN_W'(MIN_SEC_MAX);
    localparam logic [SEC_W-1:0]  S_MAX     = SEC_W'(MIN_SEC_MAX);

    logic mode_p, inc_p, inc_level;
    logic mode_level_unused;  // only the MODE edge matters

    btn_sync_edge u_mode (.clk(clk), .reset(reset), .raw(bus.btn_mode), .level(mode_level_unused), .pulse(mode_p));
    btn_sync_edge u_inc  (.clk(clk), .reset(reset), .raw(bus.btn_inc),  .level(inc_level),         .pulse(inc_p));

    state_t             state;
    field_t             cur_field;
    logic [HOUR_W-1:0]  edit_h;
    logic [MIN_W-1:0]   edit_m;
    logic [SEC_W-1:0]   edit_s;
    logic               blink_phase;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               repeat_ev, inc_ev, timeout_hit;

    // Auto-repeat fires on ticks once INC has already been held HOLD_TICKS ticks.
    assign repeat_ev   = bus.tick && inc_level && (hold_cnt == HOLD_SAT);
    assign inc_ev      = inc_p | repeat_ev;
    assign timeout_hit = bus.tick && !inc_p && (idle_cnt == IDLE_LAST);

    // Field currently being edited, derived from the state.
    always_comb begin
        cur_field = FIELD_NONE;
        case (state)
            ST_SET_H: cur_field = FIELD_HOURS;
            ST_SET_M: cur_field = FIELD_MINUTES;
            ST_SET_S: cur_field = FIELD_SECONDS;
            default:  cur_field = FIELD_NONE;
        endcase
    end

    // Count ticks of continuous INC hold; release clears, saturates at HOLD_TICKS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hold_cnt <= '0;
        else if (!inc_level)
            hold_cnt <= '0;
        else if (bus.tick && hold_cnt != HOLD_SAT)
            hold_cnt <= hold_cnt + HOLD_W'(1);
    end

    // Main edit FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= ST_RUN;
            edit_h           <= '0;
            edit_m           <= '0;
            edit_s           <= '0;
            blink_phase      <= 1'b0;
            idle_cnt         <= '0;
            bus.run_en       <= 1'b1;
            bus.load         <= 1'b0;
            bus.load_hours   <= '0;
            bus.load_minutes <= '0;
            bus.load_seconds <= '0;
            bus.edit_field   <= FIELD_NONE;
            bus.blank_mask   <= 3'b000;
        end else begin
            bus.load <= 1'b0;
            case (state)
                ST_RUN: begin
                    bus.run_en     <= 1'b1;
                    bus.edit_field <= FIELD_NONE;
                    bus.blank_mask <= 3'b000;
                    if (mode_p) begin
                        edit_h         <= bus.q_hours;
                        edit_m         <= bus.q_minutes;
                        edit_s         <= bus.q_seconds;
                        blink_phase    <= 1'b0;
                        idle_cnt       <= '0;
                        state          <= ST_SET_H;
                        bus.run_en     <= 1'b0;
                        bus.edit_field <= FIELD_HOURS;
                    end
                end
                ST_SET_H, ST_SET_M, ST_SET_S: begin
                    if (mode_p) begin
                        // Field change: restart blink and idle, drop any same-cycle INC.
                        blink_phase    <= 1'b0;
                        idle_cnt       <= '0;
                        bus.blank_mask <= 3'b000;
                        case (state)
                            ST_SET_H: begin
                                state          <= ST_SET_M;
                                bus.edit_field <= FIELD_MINUTES;
                            end
                            ST_SET_M: begin
                                state          <= ST_SET_S;
                                bus.edit_field <= FIELD_SECONDS;
                            end
                            default: begin
                                state            <= ST_COMMIT;
                                bus.edit_field   <= FIELD_NONE;
                                bus.load         <= 1'b1;
                                bus.load_hours   <= edit_h;
                                bus.load_minutes <= edit_m;
                                bus.load_seconds <= edit_s;
                            end
                        endcase
                    end else if (timeout_hit) begin
                        state          <= ST_RUN;
                        bus.run_en     <= 1'b1;
                        bus.edit_field <= FIELD_NONE;
                        bus.blank_mask <= 3'b000;
                    end else begin
                        if (inc_ev) begin
                            case (state)
                                ST_SET_H: edit_h <= (edit_h >= H_MAX) ? '0 : edit_h + HOUR_W'(1);
                                ST_SET_M: edit_m <= (edit_m >= M_MAX) ? '0 : edit_m + MIN_W'(1);
                                default:  edit_s <= (edit_s >= S_MAX) ? '0 : edit_s + SEC_W'(1);
                            endcase
                        end
                        if (inc_p)
                            idle_cnt <= '0;
                        else if (bus.tick)
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        if (bus.tick) begin
                            blink_phase    <= ~blink_phase;
                            bus.blank_mask <= field_mask(cur_field, ~blink_phase);
                        end
                    end
                end
                ST_COMMIT: begin
                    state      <= ST_RUN;
                    bus.run_en <= 1'b1;
                end
                default: begin
                    state          <= ST_RUN;
                    bus.run_en     <= 1'b1;
                    bus.edit_field <= FIELD_NONE;
                    bus.blank_mask <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus randomized edits.
module tb_clock_set_ctrl;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    clock_set_ctrl_if bus();

    clock_set_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Load monitor: counts load cycles, captures loaded time and run_en around it.
    int         load_cycles = 0;
    logic [4:0] cap_h = '0;
    logic [5:0] cap_m = '0;
    logic [5:0] cap_s = '0;
    logic       cap_run = 1'b0;
    logic       post_run = 1'b0;
    logic       prev_load = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (prev_load) post_run = bus.run_en;
            prev_load = bus.load;
            if (bus.load === 1'b1) begin
                load_cycles++;
                cap_h   = bus.load_hours;
                cap_m   = bus.load_minutes;
                cap_s   = bus.load_seconds;
                cap_run = bus.run_en;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
    endtask

    task automatic press_mode();
        bus.btn_mode = 1'b1;
        cyc(4);
        bus.btn_mode = 1'b0;
        cyc(4);
    endtask

    task automatic press_inc();
        bus.btn_inc = 1'b1;
        cyc(4);
        bus.btn_inc = 1'b0;
        cyc(4);
    endtask

    task automatic hold_inc(input int n);
        bus.btn_inc = 1'b1;
        cyc(4);
        repeat (n) begin
            do_tick();
            cyc(1);
        end
        bus.btn_inc = 1'b0;
        cyc(4);
    endtask

    task automatic set_q(input int h, input int m, input int s);
        bus.q_hours   = 5'(h);
        bus.q_minutes = 6'(m);
        bus.q_seconds = 6'(s);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.tick = 0; bus.btn_mode = 0; bus.btn_inc = 0;
        set_q(12, 34, 56);
        cyc(3);
        reset = 1'b1;
        cyc(2);
        checks++;
        if ({bus.run_en, bus.load, bus.blank_mask, bus.edit_field} !== 7'b1_0_000_00) begin
            errors++;
            $display("FAIL reset_outputs run/load/blank/field got %b%b %b %b want 10 000 00",
                     bus.run_en, bus.load, bus.blank_mask, bus.edit_field);
        end
        checks++;
        if ({bus.load_hours, bus.load_minutes, bus.load_seconds} !== 17'd0) begin
            errors++;
            $display("FAIL reset_load_vals got %0d:%0d:%0d want 0:0:0",
                     bus.load_hours, bus.load_minutes, bus.load_seconds);
        end
    endtask

    task automatic test_basic_sequence();
        int lc;
        set_q(12, 34, 56);
        press_mode();
        checks++;
        if (bus.run_en !== 1'b0 || bus.edit_field !== 2'd1) begin
            errors++;
            $display("FAIL enter_set_h run_en=%b field=%0d want 0 1", bus.run_en, bus.edit_field);
        end
        press_inc(); press_inc();
        press_mode();
        press_inc();
        press_mode();
        checks++;
        if (bus.edit_field !== 2'd3) begin
            errors++;
            $display("FAIL field_seconds got %0d want 3", bus.edit_field);
        end
        lc = load_cycles;
        press_mode();
        checks++;
        if (load_cycles - lc != 1 || cap_run !== 1'b0) begin
            errors++;
            $display("FAIL commit_pulse loads=%0d run_en_during=%b want 1 0", load_cycles - lc, cap_run);
        end
        checks++;
        if (cap_h != 14 || cap_m != 35 || cap_s != 56) begin
            errors++;
            $display("FAIL commit_value got %0d:%0d:%0d want 14:35:56", cap_h, cap_m, cap_s);
        end
        checks++;
        if (post_run !== 1'b1 || bus.run_en !== 1'b1) begin
            errors++;
            $display("FAIL run_after_commit got %b/%b want 1", post_run, bus.run_en);
        end
    endtask

    task automatic test_wrap();
        int lc;
        set_q(23, 59, 30);
        press_mode();
        press_inc();
        press_mode();
        press_inc();
        press_mode();
        lc = load_cycles;
        press_mode();
        checks++;
        if (load_cycles - lc != 1 || cap_h != 0 || cap_m != 0 || cap_s != 30) begin
            errors++;
            $display("FAIL wrap got %0d:%0d:%0d loads=%0d want 0:0:30 loads=1",
                     cap_h, cap_m, cap_s, load_cycles - lc);
        end
    endtask

    task automatic test_blink();
        int lc;
        set_q(5, 6, 7);
        press_mode();
        checks++;
        if (bus.blank_mask !== 3'b000) begin
            errors++; $display("FAIL blink_entry got %b want 000", bus.blank_mask);
        end
        do_tick();
        checks++;
        if (bus.blank_mask !== 3'b100) begin
            errors++; $display("FAIL blink_h_on got %b want 100", bus.blank_mask);
        end
        do_tick();
        checks++;
        if (bus.blank_mask !== 3'b000) begin
            errors++; $display("FAIL blink_h_off got %b want 000", bus.blank_mask);
        end
        do_tick();
        press_mode();
        checks++;
        if (bus.blank_mask !== 3'b000 || bus.edit_field !== 2'd2) begin
            errors++; $display("FAIL blink_field_change got %b/%0d want 000/2", bus.blank_mask, bus.edit_field);
        end
        do_tick();
        checks++;
        if (bus.blank_mask !== 3'b010) begin
            errors++; $display("FAIL blink_m_on got %b want 010", bus.blank_mask);
        end
        press_mode();
        lc = load_cycles;
        press_mode();
        checks++;
        if (load_cycles - lc != 1 || cap_h != 5 || cap_m != 6 || cap_s != 7) begin
            errors++;
            $display("FAIL blink_commit got %0d:%0d:%0d want 5:6:7", cap_h, cap_m, cap_s);
        end
    endtask

    task automatic test_hold();
        int lc;
        set_q(3, 10, 20);
        press_mode();
        press_mode();
        hold_inc(5);
        repeat (3) begin
            do_tick();
            cyc(1);
        end
        press_mode();
        lc = load_cycles;
        press_mode();
        checks++;
        if (load_cycles - lc != 1 || cap_m != 14 || cap_h != 3 || cap_s != 20) begin
            errors++;
            $display("FAIL hold_repeat got %0d:%0d:%0d want 3:14:20", cap_h, cap_m, cap_s);
        end
    endtask

    task automatic test_timeout();
        int lc;
        set_q(8, 9, 10);
        press_mode(); press_mode(); press_mode();
        lc = load_cycles;
        for (int i = 1; i <= 30; i++) begin
            do_tick();
            if (i == 29) begin
                checks++;
                if (bus.edit_field !== 2'd3 || bus.run_en !== 1'b0 || bus.blank_mask !== 3'b001) begin
                    errors++;
                    $display("FAIL timeout_early field=%0d run_en=%b blank=%b want 3 0 001",
                             bus.edit_field, bus.run_en, bus.blank_mask);
                end
            end
        end
        checks++;
        if (bus.run_en !== 1'b1 || bus.edit_field !== 2'd0 || bus.blank_mask !== 3'b000) begin
            errors++;
            $display("FAIL timeout_abort run_en=%b field=%0d blank=%b want 1 0 000",
                     bus.run_en, bus.edit_field, bus.blank_mask);
        end
        cyc(4);
        checks++;
        if (load_cycles != lc) begin
            errors++; $display("FAIL timeout_no_load loads=%0d want 0", load_cycles - lc);
        end
    endtask

    task automatic test_mode_inc_same();
        int lc;
        set_q(7, 20, 40);
        press_mode();
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        cyc(4);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        cyc(4);
        checks++;
        if (bus.edit_field !== 2'd2) begin
            errors++; $display("FAIL same_cycle_field got %0d want 2", bus.edit_field);
        end
        press_mode();
        lc = load_cycles;
        press_mode();
        checks++;
        if (load_cycles - lc != 1 || cap_h != 7 || cap_m != 20 || cap_s != 40) begin
            errors++;
            $display("FAIL same_cycle_value got %0d:%0d:%0d want 7:20:40", cap_h, cap_m, cap_s);
        end
    endtask

    task automatic test_reset_mid_edit();
        int lc;
        set_q(1, 2, 3);
        press_mode(); press_mode();
        lc = load_cycles;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.run_en, bus.load, bus.blank_mask, bus.edit_field} !== 7'b1_0_000_00 ||
            {bus.load_hours, bus.load_minutes, bus.load_seconds} !== 17'd0) begin
            errors++;
            $display("FAIL reset_mid_edit run/load/blank/field=%b%b %b %b vals=%0d:%0d:%0d",
                     bus.run_en, bus.load, bus.blank_mask, bus.edit_field,
                     bus.load_hours, bus.load_minutes, bus.load_seconds);
        end
        cyc(2);
        reset = 1'b1;
        cyc(4);
        checks++;
        if (load_cycles != lc || bus.run_en !== 1'b1 || bus.edit_field !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_edit_after loads=%0d run_en=%b field=%0d want 0 1 0",
                     load_cycles - lc, bus.run_en, bus.edit_field);
        end
    endtask

    // Randomized edits: expected field = (start + presses + repeats) mod (max+1).
    task automatic test_random();
        int lc, start[3], expv[3], modv[3];
        modv = '{24, 60, 60};
        for (int it = 0; it < 6; it++) begin
            start[0] = $urandom_range(0, 23);
            start[1] = $urandom_range(0, 59);
            start[2] = $urandom_range(0, 59);
            set_q(start[0], start[1], start[2]);
            press_mode();
            set_q($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            for (int f = 0; f < 3; f++) begin
                int np, nt, steps;
                np = $urandom_range(0, 3);
                steps = np;
                repeat (np) press_inc();
                if ($urandom_range(0, 1) == 1) begin
                    nt = $urandom_range(0, 5);
                    hold_inc(nt);
                    steps += 1 + ((nt > 2) ? nt - 2 : 0);
                end
                repeat ($urandom_range(0, 2)) begin
                    do_tick();
                    cyc(1);
                end
                expv[f] = (start[f] + steps) % modv[f];
                if (f < 2) press_mode();
            end
            lc = load_cycles;
            press_mode();
            checks++;
            if (load_cycles - lc != 1 || cap_h != expv[0] || cap_m != expv[1] || cap_s != expv[2]) begin
                errors++;
                $display("FAIL random_%0d got %0d:%0d:%0d loads=%0d want %0d:%0d:%0d loads=1",
                         it, cap_h, cap_m, cap_s, load_cycles - lc, expv[0], expv[1], expv[2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sequence();
        test_wrap();
        test_blink();
        test_hold();
        test_timeout();
        test_mode_inc_same();
        test_reset_mid_edit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
